// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset encodings: opcodes, R-type functs, request kinds, loader FSM states.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package mips_isa_pkg;

    // Primary opcodes, shared with the control decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes the datapath implements
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Symbolic request class; codes 6 and 7 are deliberately left unassigned
    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_LW    = 3'd1,
        K_SW    = 3'd2,
        K_BEQ   = 3'd3,
        K_ADDI  = 3'd4,
        K_J     = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request stream into the loader plus the instruction-memory write port out of it.
// Latency: n/a (wires only).
// Backpressure: in_ready from the loader gates the request stream; the write port has none.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        in_kind;
    logic [5:0]        in_funct;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_last, in_kind, in_funct, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_kind, in_funct, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_field_pack.sv
// Packs a symbolic request (kind + fields) into a 32-bit MIPS word and flags unsupported requests.
// Latency: purely combinational.
// Backpressure: none.
module instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the field layout for the class; unknown kinds and unimplemented functs are illegal
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            K_RTYPE: begin
                word    = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
                illegal = !funct_legal(funct);
            end
            K_LW:    word = {OP_LW,   rs, rt, imm};
            K_SW:    word = {OP_SW,   rs, rt, imm};
            K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
            K_ADDI:  word = {OP_ADDI, rs, rt, imm};
            K_J:     word = {OP_J,    target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests and writes them sequentially into instruction memory.
// Latency: 1 cycle from request acceptance to imem write; one word per cycle sustained.
// Backpressure: none while loading (in_ready held high in LOAD); in_ready low elsewhere.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_e            state;
    logic [ADDR_W-1:0] addr_ptr;
    logic              last_seen;   // final word is on the write port; DONE follows next edge
    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic              full;

    instr_field_pack u_pack (
        .kind    (bus.in_kind),
        .funct   (bus.in_funct),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (word),
        .illegal (illegal)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign full   = (count == CNT_MAX);

    // Session FSM with registered handshake, write port and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            addr_ptr       <= '0;
            last_seen      <= 1'b0;
            count          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        addr_ptr     <= base_addr;
                        count        <= '0;
                        err          <= 1'b0;
                        last_seen    <= 1'b0;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (last_seen) begin
                        state     <= ST_DONE;
                        last_seen <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (accept) begin
                        if (illegal || full) begin
                            // Faulting request: nothing written, pointer and count frozen
                            state        <= ST_ERR;
                            err          <= 1'b1;
                            busy         <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= addr_ptr;
                            bus.imem_wdata <= word;
                            addr_ptr       <= addr_ptr + 1'b1;   // wraps modulo 2**ADDR_W
                            count          <= count + CNT_W'(1);
                            if (bus.in_last) begin
                                last_seen    <= 1'b1;
                                bus.in_ready <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } req_s;

    req_s        reqs[$];
    logic [31:0] mem [0:63];
    logic [31:0] exp_mem [0:63];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          legal_fn [5] = '{32, 34, 36, 37, 42};

    // Instruction memory stand-in plus write / done pulse counters
    always @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_addr] <= bus.imem_wdata;
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoding from the ISA field layout
    function automatic logic [31:0] itype(input int op, input req_s r);
        return (32'(op) << 26) | (32'(r.rs) << 21) | (32'(r.rt) << 16) | 32'(r.imm);
    endfunction

    function automatic logic [31:0] ref_word(input req_s r);
        case (r.kind)
            3'd0:    return (32'(r.rs) << 21) | (32'(r.rt) << 16) | (32'(r.rd) << 11) | 32'(r.funct);
            3'd1:    return itype(35, r);
            3'd2:    return itype(43, r);
            3'd3:    return itype(4, r);
            3'd4:    return itype(8, r);
            3'd5:    return (32'd2 << 26) | 32'(r.target);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_fault(input req_s r);
        bit ok_fn = 1'b0;
        for (int k = 0; k < 5; k++) if (int'(r.funct) == legal_fn[k]) ok_fn = 1'b1;
        return (r.kind > 3'd5) || (r.kind == 3'd0 && !ok_fn);
    endfunction

    // Request with every field randomised first, then the meaningful ones overridden
    function automatic req_s rq(input int kind, input int funct, input int rs, input int rt,
                                input int rd, input int imm, input int target);
        req_s r;
        r        = req_s'({$urandom, $urandom, $urandom});
        r.kind   = 3'(kind);
        r.funct  = 6'(funct);
        r.rs     = 5'(rs);
        r.rt     = 5'(rt);
        r.rd     = 5'(rd);
        r.imm    = 16'(imm);
        r.target = 26'(target);
        return r;
    endfunction

    function automatic req_s rnd_req();
        int k = int'($urandom_range(0, 9));
        int f;
        if (k > 7) k = 0;
        f = ($urandom_range(0, 4) != 0) ? legal_fn[$urandom_range(0, 4)] : int'($urandom_range(0, 63));
        return rq(k, f, $urandom, $urandom, $urandom, $urandom, $urandom);
    endfunction

    // Run one load session over reqs[], checking every cycle against the model
    task automatic run_session(input string name, input int base, input bit poke_start);
        int m_addr;
        int m_count;
        int wr0;
        int dn0;
        bit faulted;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        tick();
        start = 1'b0;
        check({name, "_busy"},   64'(busy), 64'(1));
        check({name, "_ready"},  64'(bus.in_ready), 64'(1));
        check({name, "_cnt0"},   64'(count), 64'(0));
        check({name, "_errclr"}, 64'(err), 64'(0));
        m_addr  = base;
        m_count = 0;
        faulted = 1'b0;
        wr0     = wr_cnt;
        dn0     = done_cnt;
        for (int i = 0; i < reqs.size(); i++) begin
            bus.in_valid  = 1'b1;
            bus.in_last   = (i == reqs.size() - 1);
            bus.in_kind   = reqs[i].kind;
            bus.in_funct  = reqs[i].funct;
            bus.in_rs     = reqs[i].rs;
            bus.in_rt     = reqs[i].rt;
            bus.in_rd     = reqs[i].rd;
            bus.in_imm    = reqs[i].imm;
            bus.in_target = reqs[i].target;
            if (poke_start && i == 0) begin
                start     = 1'b1;
                base_addr = ADDR_W'(base + 17);
            end
            tick();
            start = 1'b0;
            if (ref_fault(reqs[i]) || m_count == MAX_WORDS) begin
                check({name, "_fault_we"},   64'(bus.imem_we), 64'(0));
                check({name, "_fault_err"},  64'(err), 64'(1));
                check({name, "_fault_busy"}, 64'(busy), 64'(0));
                check({name, "_fault_cnt"},  64'(count), 64'(m_count));
                faulted = 1'b1;
                break;
            end
            check({name, "_we"},   64'(bus.imem_we), 64'(1));
            check({name, "_addr"}, 64'(bus.imem_addr), 64'(m_addr % 64));
            check({name, "_data"}, 64'(bus.imem_wdata), 64'(ref_word(reqs[i])));
            exp_mem[m_addr % 64] = ref_word(reqs[i]);
            m_addr++;
            m_count++;
            check({name, "_count"}, 64'(count), 64'(m_count));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (faulted) begin
            tick();
            check({name, "_err_hold"},  64'(err), 64'(1));
            check({name, "_err_rdy"},   64'(bus.in_ready), 64'(0));
            check({name, "_err_we"},    64'(bus.imem_we), 64'(0));
            check({name, "_err_nodone"}, 64'(done_cnt - dn0), 64'(0));
        end else begin
            check({name, "_last_rdy"}, 64'(bus.in_ready), 64'(0));
            tick();
            check({name, "_done"},     64'(done), 64'(1));
            check({name, "_done_we"},  64'(bus.imem_we), 64'(0));
            check({name, "_done_rdy"}, 64'(bus.in_ready), 64'(0));
            tick();
            check({name, "_done_off"}, 64'(done), 64'(0));
            check({name, "_idle_busy"}, 64'(busy), 64'(0));
            check({name, "_one_done"}, 64'(done_cnt - dn0), 64'(1));
        end
        check({name, "_writes"}, 64'(wr_cnt - wr0), 64'(m_count));
    endtask

    initial begin
        int wr0;
        int dn0;
        reset         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_kind   = '0;
        bus.in_funct  = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_imm    = '0;
        bus.in_target = '0;

        // Reset state
        #12;
        check("rst_ready", 64'(bus.in_ready), 64'(0));
        check("rst_we",    64'(bus.imem_we), 64'(0));
        check("rst_addr",  64'(bus.imem_addr), 64'(0));
        check("rst_wdata", 64'(bus.imem_wdata), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_flags", 64'({busy, done, err}), 64'(0));
        reset = 1'b1;
        tick();

        // Single R-type add
        reqs = {};
        reqs.push_back(rq(0, 6'b100000, 9, 10, 8, $urandom, $urandom));
        run_session("radd", 0, 1'b0);
        check("radd_word", 64'(mem[0]), 64'(32'h012A4020));

        // Back-to-back I-type and jump words
        reqs = {};
        reqs.push_back(rq(1, $urandom, 0, 2, $urandom, 16'h0044, $urandom));
        reqs.push_back(rq(4, $urandom, 0, 2, $urandom, 5, $urandom));
        reqs.push_back(rq(3, $urandom, 4, 5, $urandom, 16'hFFFF, $urandom));
        reqs.push_back(rq(5, $urandom, $urandom, $urandom, $urandom, $urandom, 26'h11));
        run_session("b2b", 0, 1'b0);
        check("b2b_w0",  64'(mem[0]), 64'(32'h8C020044));
        check("b2b_w1",  64'(mem[1]), 64'(32'h20020005));
        check("b2b_w2",  64'(mem[2]), 64'(32'h1085FFFF));
        check("b2b_w3",  64'(mem[3]), 64'(32'h08000011));
        check("b2b_cnt", 64'(count), 64'(4));

        // Address wrap, with a stray start mid-session that must be ignored
        reqs = {};
        for (int i = 0; i < 3; i++) reqs.push_back(rq(2, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        run_session("wrap", 62, 1'b1);
        check("wrap_err", 64'(err), 64'(0));

        // Unsupported kind, then illegal funct
        reqs = {};
        reqs.push_back(rq(6, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        run_session("kind6", 3, 1'b0);
        reqs = {};
        reqs.push_back(rq(4, $urandom, 1, 1, $urandom, 7, $urandom));
        reqs.push_back(rq(0, 0, 1, 2, 3, $urandom, $urandom));
        reqs.push_back(rq(4, $urandom, 1, 1, $urandom, 9, $urandom));
        run_session("badfn", 20, 1'b0);

        // Overflow past MAX_WORDS
        reqs = {};
        for (int i = 0; i < MAX_WORDS + 1; i++) reqs.push_back(rq(4, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        run_session("ovf", int'($urandom_range(0, 63)), 1'b0);

        // Randomised sessions
        for (int s = 0; s < 20; s++) begin
            int n = int'($urandom_range(1, 8));
            reqs = {};
            for (int i = 0; i < n; i++) reqs.push_back(rnd_req());
            run_session("rnd", int'($urandom_range(0, 63)), 1'b0);
        end

        // Reset mid-session after two of four writes
        reqs = {};
        for (int i = 0; i < 4; i++) reqs.push_back(rq(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        wr0       = wr_cnt;
        dn0       = done_cnt;
        start     = 1'b1;
        base_addr = ADDR_W'(10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_kind   = reqs[i].kind;
            bus.in_rs     = reqs[i].rs;
            bus.in_rt     = reqs[i].rt;
            bus.in_imm    = reqs[i].imm;
            tick();
            check("mid_we", 64'(bus.imem_we), 64'(1));
        end
        bus.in_valid = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.in_ready), 64'(0));
        check("mid_rst_port",  64'({bus.imem_we, bus.imem_addr, bus.imem_wdata}), 64'(0));
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_flags", 64'({busy, done, err}), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_nodone", 64'(done_cnt - dn0), 64'(0));
        check("mid_writes", 64'(wr_cnt - wr0), 64'(2));
        check("mid_mem0",   64'(mem[10]), 64'(ref_word(reqs[0])));
        check("mid_mem1",   64'(mem[11]), 64'(ref_word(reqs[1])));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
